// File: rtl/tb_gpio_stim.sv
// Multi-channel pin stimulus generator: static, LFSR-random, one-shot pulse and toggle modes.
// Define TB_GPIO_STIM_GLITCH_EN to add rare single-cycle glitches to static channels.
module tb_gpio_stim #(
    parameter int          NUM_CH   = 2,
    parameter int          HOLD_W   = 8,
    parameter int          MIN_HOLD = 4,
    parameter logic [31:0] SEED     = 32'h0000_0001
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NUM_CH-1:0]     cfg_en,
    input  logic [2*NUM_CH-1:0]   cfg_mode,
    input  logic [NUM_CH-1:0]     cfg_level,
    input  logic [HOLD_W-1:0]     cfg_period,
    input  logic [NUM_CH-1:0]     trig,
    output logic [NUM_CH-1:0]     pin_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_RANDOM = 2'b01,
        MODE_PULSE  = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ch_state_e;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0]     C_TAPS = 32'h8020_0003;
    localparam logic [31:0]     C_SEED = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [HOLD_W:0] C_MH1  = (HOLD_W+1)'(MIN_HOLD - 1);

    logic [31:0]                   r_lfsr;
    logic [NUM_CH-1:0]             r_pin;
    logic [NUM_CH-1:0][HOLD_W-1:0] r_cnt;
    ch_state_e                     r_state [NUM_CH];
    logic [2*NUM_CH-1:0]           r_mode;
    logic                          r_busy;

    logic [31:0]                   w_lfsr_nxt;
    logic [NUM_CH-1:0]             w_pin_nxt;
    logic [NUM_CH-1:0][HOLD_W-1:0] w_cnt_nxt;
    ch_state_e                     w_state_nxt [NUM_CH];
    logic                          w_busy_nxt;
    logic [HOLD_W-1:0]             w_per_m1;
    logic [HOLD_W-1:0]             w_r;
    logic [HOLD_W:0]               w_sum;
    logic [HOLD_W-1:0]             w_hold;
    mode_e                         w_mode;

    always_comb begin
        w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? C_TAPS : 32'h0);
        w_per_m1   = (cfg_period == '0) ? '0 : cfg_period - 1'b1;
        w_pin_nxt  = r_pin;
        w_cnt_nxt  = r_cnt;
        w_busy_nxt = 1'b0;
        w_r        = '0;
        w_sum      = '0;
        w_hold     = '0;
        w_mode     = MODE_STATIC;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_mode = mode_e'(cfg_mode[2*i +: 2]);
            // Random hold: MIN_HOLD-1 plus low bits of the LFSR rotated right by the channel index.
            w_r    = HOLD_W'({r_lfsr, r_lfsr} >> i);
            w_sum  = {1'b0, w_r} + C_MH1;
            w_hold = w_sum[HOLD_W] ? '1 : w_sum[HOLD_W-1:0];

            if (!cfg_en[i] || (cfg_mode[2*i +: 2] != r_mode[2*i +: 2])) begin
                w_pin_nxt[i]   = cfg_level[i];
                w_cnt_nxt[i]   = '0;
                w_state_nxt[i] = ST_IDLE;
            end else begin
                case (w_mode)
                    MODE_STATIC: begin
`ifdef TB_GPIO_STIM_GLITCH_EN
                        w_pin_nxt[i] = cfg_level[i] ^ ((r_lfsr[7:0] == 8'hA5) && r_lfsr[(8+i)%32]);
`else
                        w_pin_nxt[i] = cfg_level[i];
`endif
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = ST_IDLE;
                    end
                    MODE_RANDOM: begin
                        if (r_cnt[i] == '0) begin
                            w_pin_nxt[i] = r_lfsr[i];
                            w_cnt_nxt[i] = w_hold;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                        end
                    end
                    MODE_PULSE: begin
                        if (r_state[i] == ST_IDLE) begin
                            w_pin_nxt[i] = cfg_level[i];
                            if (trig[i]) begin
                                w_pin_nxt[i]   = ~cfg_level[i];
                                w_cnt_nxt[i]   = w_per_m1;
                                w_state_nxt[i] = ST_ACTIVE;
                            end
                        end else if (r_cnt[i] == '0) begin
                            // Ending cycle: a trig seen here is deliberately dropped.
                            w_pin_nxt[i]   = cfg_level[i];
                            w_state_nxt[i] = ST_IDLE;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                        end
                    end
                    default: begin
                        if (r_cnt[i] == '0) begin
                            w_pin_nxt[i] = ~r_pin[i];
                            w_cnt_nxt[i] = w_per_m1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                        end
                    end
                endcase
            end
            w_busy_nxt = w_busy_nxt | (w_state_nxt[i] == ST_ACTIVE);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_lfsr <= C_SEED;
            r_pin  <= '1;
            r_cnt  <= '0;
            r_mode <= '0;
            r_busy <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
            end
        end else begin
            r_lfsr <= w_lfsr_nxt;
            r_pin  <= w_pin_nxt;
            r_cnt  <= w_cnt_nxt;
            r_mode <= cfg_mode;
            r_busy <= w_busy_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    assign pin_o  = r_pin;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_tb_gpio_stim.sv
// Directed bench for tb_gpio_stim (NUM_CH=2, HOLD_W=8, MIN_HOLD=4, SEED=1).
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_tb_gpio_stim;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] cfg_en;
    logic [3:0] cfg_mode;
    logic [1:0] cfg_level;
    logic [7:0] cfg_period;
    logic [1:0] trig;
    logic [1:0] pin_o;
    logic       busy_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_lfsr = 32'h1;
    logic [1:0]  exp_q[$];

    tb_gpio_stim #(
        .NUM_CH(2), .HOLD_W(8), .MIN_HOLD(4), .SEED(32'h0000_0001)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_level(cfg_level), .cfg_period(cfg_period), .trig(trig),
        .pin_o(pin_o), .busy_o(busy_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference LFSR, reloaded whenever reset is sampled.
    always @(posedge sys_clk) m_lfsr <= sys_rst ? 32'h1 : lfsr_step(m_lfsr);

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; cfg_en = 2'b00; cfg_mode = 4'b0000; cfg_level = 2'b01;
        cfg_period = 8'd0; trig = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (pin_o !== 2'b11 || busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: pin_o=%b busy_o=%b, required pin_o=11 busy_o=0", c, pin_o, busy_o);
            end
        end
        sys_rst = 1'b0;
        tick();
        n_vec++;
        if (pin_o !== 2'b01 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: pin_o=%b busy_o=%b, required pin_o=01 busy_o=0", pin_o, busy_o);
        end
    endtask

    task automatic test_pulse();
        cfg_en = 2'b01; cfg_mode = 4'b0010; cfg_level = 2'b01; cfg_period = 8'd5; trig = 2'b00;
        tick(); tick();
        n_vec++;
        if (pin_o !== 2'b01 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL pulse_idle: pin_o=%b busy_o=%b, required pin_o=01 busy_o=0", pin_o, busy_o);
        end
        trig = 2'b01;
        tick();
        trig = 2'b00;
        for (int c = 1; c <= 5; c++) begin
            n_vec++;
            if (pin_o !== 2'b00 || busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL pulse_low[%0d]: pin_o=%b busy_o=%b, required pin_o=00 busy_o=1", c, pin_o, busy_o);
            end
            trig = (c == 2 || c == 5) ? 2'b01 : 2'b00;
            tick();
        end
        trig = 2'b00;
        n_vec++;
        if (pin_o !== 2'b01 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL pulse_end: pin_o=%b busy_o=%b, required pin_o=01 busy_o=0", pin_o, busy_o);
        end
        tick();
        n_vec++;
        if (pin_o !== 2'b01 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL pulse_no_retrig: pin_o=%b busy_o=%b, required pin_o=01 busy_o=0", pin_o, busy_o);
        end
    endtask

    task automatic test_toggle();
        logic [1:0] e;
        cfg_en = 2'b10; cfg_mode = 4'b1100; cfg_level = 2'b00; cfg_period = 8'd0; trig = 2'b00;
        tick();
        n_vec++;
        if (pin_o !== 2'b00) begin
            n_err++;
            $display("FAIL toggle_restart: pin_o=%b, required 00", pin_o);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = {k[0], 1'b0};
            n_vec++;
            if (pin_o !== e) begin
                n_err++;
                $display("FAIL toggle_p0[%0d]: pin_o=%b, required %b", k, pin_o, e);
            end
        end
        cfg_period = 8'd3;
        for (int k = 0; k < 12; k++) begin
            tick();
            e = {((k / 3) % 2 == 0), 1'b0};
            n_vec++;
            if (pin_o !== e) begin
                n_err++;
                $display("FAIL toggle_p3[%0d]: pin_o=%b, required %b", k, pin_o, e);
            end
        end
    endtask

    task automatic test_midop();
        cfg_en = 2'b01; cfg_mode = 4'b0010; cfg_level = 2'b01; cfg_period = 8'd5; trig = 2'b00;
        tick(); tick();
        trig = 2'b01; tick(); trig = 2'b00; tick();
        n_vec++;
        if (pin_o !== 2'b00 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL midop_pulse_c2: pin_o=%b busy_o=%b, required pin_o=00 busy_o=1", pin_o, busy_o);
        end
        cfg_en = 2'b00;
        tick();
        n_vec++;
        if (pin_o !== 2'b01 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL midop_disable: pin_o=%b busy_o=%b, required pin_o=01 busy_o=0", pin_o, busy_o);
        end
        cfg_en = 2'b01;
        tick();
        n_vec++;
        if (pin_o !== 2'b01 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reenable: pin_o=%b busy_o=%b, required pin_o=01 busy_o=0", pin_o, busy_o);
        end
        trig = 2'b01; tick(); trig = 2'b00; tick();
        sys_rst = 1'b1;
        tick();
        n_vec++;
        if (pin_o !== 2'b11 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reset: pin_o=%b busy_o=%b, required pin_o=11 busy_o=0", pin_o, busy_o);
        end
        sys_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (pin_o !== 2'b01 || busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL midop_after_reset[%0d]: pin_o=%b busy_o=%b, required pin_o=01 busy_o=0", c, pin_o, busy_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       act;
        logic [1:0] e;
        cfg_en = 2'b11; cfg_mode = 4'b1010; cfg_level = 2'b10; cfg_period = 8'd2; trig = 2'b00;
        tick(); tick();
        n_vec++;
        if (pin_o !== 2'b10 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: pin_o=%b busy_o=%b, required pin_o=10 busy_o=0", pin_o, busy_o);
        end
        // Trig held high: two active cycles, one ignored ending cycle, then a fresh start.
        trig = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            act = (k % 3 != 2);
            e = act ? 2'b01 : 2'b10;
            n_vec++;
            if (pin_o !== e || busy_o !== act) begin
                n_err++;
                $display("FAIL b2b_trig[%0d]: pin_o=%b busy_o=%b, required pin_o=%b busy_o=%b", k, pin_o, busy_o, e, act);
            end
        end
        trig = 2'b00;
        tick();
        n_vec++;
        if (pin_o !== 2'b10 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: pin_o=%b busy_o=%b, required pin_o=10 busy_o=0", pin_o, busy_o);
        end
    endtask

    // ch0 random, ch1 static level 1; exact model from the LFSR reference.
    task automatic test_random(input int n_cyc, input bit record);
        int         m_cnt;
        int         sum;
        int         run_len;
        int         short_runs;
        int         mism;
        int         q_mism;
        logic       e0;
        logic       e1;
        logic       run_val;
        logic       seen0;
        logic       seen1;
        logic [1:0] act_first;
        logic [1:0] exp_first;
        logic [1:0] qv;
        cfg_en = 2'b11; cfg_mode = 4'b0001; cfg_level = 2'b10; cfg_period = 8'd0; trig = 2'b00;
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        n_vec++;
        if (pin_o !== 2'b11) begin
            n_err++;
            $display("FAIL random_reset: pin_o=%b, required 11", pin_o);
        end
        m_cnt = 0; e0 = 1'b0; mism = 0; q_mism = 0; short_runs = 0;
        run_len = 0; run_val = 1'b0; seen0 = 1'b0; seen1 = 1'b0;
        act_first = 2'b00; exp_first = 2'b00;
        for (int s = 0; s < n_cyc; s++) begin
            if (s == 0) begin
                e0 = cfg_level[0];
                m_cnt = 0;
            end else if (m_cnt == 0) begin
                e0 = m_lfsr[0];
                sum = 3 + int'(m_lfsr[7:0]);
                m_cnt = (sum > 255) ? 255 : sum;
            end else begin
                m_cnt = m_cnt - 1;
            end
`ifdef TB_GPIO_STIM_GLITCH_EN
            e1 = 1'b1 ^ ((m_lfsr[7:0] == 8'hA5) && m_lfsr[9]);
`else
            e1 = 1'b1;
`endif
            tick();
            if (pin_o !== {e1, e0} || busy_o !== 1'b0) begin
                if (mism == 0) begin
                    act_first = pin_o;
                    exp_first = {e1, e0};
                end
                mism++;
            end
            if (record) begin
                exp_q.push_back(pin_o);
            end else if (exp_q.size() > 0) begin
                qv = exp_q.pop_front();
                if (pin_o !== qv) q_mism++;
            end
            if (s >= 1) begin
                if (pin_o[0]) seen1 = 1'b1; else seen0 = 1'b1;
                if (s == 1) begin
                    run_val = pin_o[0];
                    run_len = 1;
                end else if (pin_o[0] === run_val) begin
                    run_len++;
                end else begin
                    if (run_len < 4) short_runs++;
                    run_val = pin_o[0];
                    run_len = 1;
                end
            end
        end
        n_vec++;
        if (mism != 0) begin
            n_err++;
            $display("FAIL random_model: %0d cycles differ, first pin_o=%b required %b", mism, act_first, exp_first);
        end
        n_vec++;
        if (short_runs != 0) begin
            n_err++;
            $display("FAIL random_min_hold: %0d runs shorter than 4 cycles, required 0", short_runs);
        end
        n_vec++;
        if (!(seen0 && seen1)) begin
            n_err++;
            $display("FAIL random_levels: seen0=%b seen1=%b, required both 1", seen0, seen1);
        end
        if (!record) begin
            n_vec++;
            if (q_mism != 0) begin
                n_err++;
                $display("FAIL random_repeat: %0d samples differ from first run, required 0", q_mism);
            end
        end
    endtask

    initial begin
        sys_rst = 1'b1; cfg_en = 2'b00; cfg_mode = 4'b0000; cfg_level = 2'b01;
        cfg_period = 8'd0; trig = 2'b00;
        test_reset();
        test_pulse();
        test_toggle();
        test_midop();
        test_back_to_back();
        test_random(10000, 1'b1);
        // Trim the recording to the length replayed in the second run.
        while (exp_q.size() > 2000) void'(exp_q.pop_back());
        test_random(2000, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
